// File: rtl/mipi_img_window.sv
// Crops the CSI-2 deserializer pixel stream to a programmable window and regenerates fvo/lvo/dvo.
// Optional frame geometry measurement (meas_width/meas_height/geom_valid) is enabled with `define MIPI_IMG_GEOM_EN.
module mipi_img_window #(
    parameter int DATA_WIDTH = 10,
    parameter int DIM_WIDTH  = 16
) (
    input  logic                  img_clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] dati,
    input  logic                  dvi,
    input  logic                  lvi,
    input  logic                  fvi,
    input  logic [DIM_WIDTH-1:0]  col_start,
    input  logic [DIM_WIDTH-1:0]  col_count,
    input  logic [DIM_WIDTH-1:0]  row_start,
    input  logic [DIM_WIDTH-1:0]  row_count,
    output logic [DATA_WIDTH-1:0] dato,
    output logic                  dvo,
    output logic                  lvo,
    output logic                  fvo,
    output logic [15:0]           frame_count
`ifdef MIPI_IMG_GEOM_EN
    ,
    output logic [DIM_WIDTH-1:0]  meas_width,
    output logic [DIM_WIDTH-1:0]  meas_height,
    output logic                  geom_valid
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SKIP,
        ST_FRAME,
        ST_LINE
    } state_t;

    state_t state, state_next;

    logic fvi_d, lvi_d, fv_armed;
    logic fv_rise, fv_fall, lv_rise, lv_fall;

    logic [DIM_WIDTH-1:0] win_col_start, win_col_count, win_row_start, win_row_count;
    logic [DIM_WIDTH-1:0] row_cnt, col_cnt, col_pos;

    logic [DATA_WIDTH-1:0] dato_n;
    logic                  dvo_n, lvo_n, fvo_n, load_win, frame_done;
    logic [DIM_WIDTH-1:0]  row_n, col_n;

    logic [DIM_WIDTH:0] col_lo, col_hi, row_lo, row_hi;
    logic               pix_in;

    function automatic logic [DIM_WIDTH-1:0] sat_inc(input logic [DIM_WIDTH-1:0] v);
        return (&v) ? v : v + DIM_WIDTH'(1);
    endfunction

    // A frame already running when reset is released must not look like a rising edge,
    // so frame starts are only honoured once fvi has been seen low.
    assign fv_rise = fvi & ~fvi_d & fv_armed;
    assign fv_fall = ~fvi & fvi_d;
    assign lv_rise = lvi & ~lvi_d;
    assign lv_fall = ~lvi & lvi_d;

    assign frame_done = ((state == ST_FRAME) || (state == ST_LINE)) && fv_fall;

    // A pixel arriving together with the lvi rise is column 0 of the new line.
    assign col_pos = (state == ST_LINE) ? col_cnt : '0;
    assign col_lo  = {1'b0, win_col_start};
    assign col_hi  = {1'b0, win_col_start} + {1'b0, win_col_count};
    assign row_lo  = {1'b0, win_row_start};
    assign row_hi  = {1'b0, win_row_start} + {1'b0, win_row_count};
    assign pix_in  = ({1'b0, row_cnt} >= row_lo) && ({1'b0, row_cnt} < row_hi) &&
                     ({1'b0, col_pos} >= col_lo) && ({1'b0, col_pos} < col_hi);

    always_ff @(posedge img_clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        dato_n     = dato;
        dvo_n      = 1'b0;
        lvo_n      = lvo;
        fvo_n      = fvo;
        row_n      = row_cnt;
        col_n      = col_cnt;
        load_win   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                lvo_n = 1'b0;
                fvo_n = 1'b0;
                if (fv_rise) begin
                    if (enable) begin
                        load_win   = 1'b1;
                        row_n      = '0;
                        fvo_n      = 1'b1;
                        state_next = ST_FRAME;
                    end else begin
                        state_next = ST_SKIP;
                    end
                end
            end
            ST_SKIP: begin
                lvo_n = 1'b0;
                fvo_n = 1'b0;
                if (fv_fall) begin
                    state_next = ST_IDLE;
                end
            end
            ST_FRAME: begin
                lvo_n = 1'b0;
                if (fv_fall) begin
                    fvo_n      = 1'b0;
                    state_next = ST_IDLE;
                end else if (lv_rise) begin
                    state_next = ST_LINE;
                    col_n      = dvi ? DIM_WIDTH'(1) : '0;
                    if (dvi && pix_in) begin
                        dato_n = dati;
                        dvo_n  = 1'b1;
                        lvo_n  = 1'b1;
                    end
                end
            end
            ST_LINE: begin
                if (fv_fall || lv_fall) begin
                    lvo_n      = 1'b0;
                    row_n      = sat_inc(row_cnt);
                    state_next = ST_FRAME;
                    if (fv_fall) begin
                        fvo_n      = 1'b0;
                        state_next = ST_IDLE;
                    end
                end else if (dvi) begin
                    col_n = sat_inc(col_cnt);
                    if (pix_in) begin
                        dato_n = dati;
                        dvo_n  = 1'b1;
                        lvo_n  = 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge img_clk) begin
        if (reset) begin
            fvi_d         <= 1'b0;
            lvi_d         <= 1'b0;
            fv_armed      <= 1'b0;
            dato          <= '0;
            dvo           <= 1'b0;
            lvo           <= 1'b0;
            fvo           <= 1'b0;
            frame_count   <= '0;
            row_cnt       <= '0;
            col_cnt       <= '0;
            win_col_start <= '0;
            win_col_count <= '0;
            win_row_start <= '0;
            win_row_count <= '0;
        end else begin
            fvi_d   <= fvi;
            lvi_d   <= lvi;
            dato    <= dato_n;
            dvo     <= dvo_n;
            lvo     <= lvo_n;
            fvo     <= fvo_n;
            row_cnt <= row_n;
            col_cnt <= col_n;
            if (!fvi) begin
                fv_armed <= 1'b1;
            end
            if (frame_done) begin
                frame_count <= frame_count + 16'd1;
            end
            if (load_win) begin
                win_col_start <= col_start;
                win_col_count <= col_count;
                win_row_start <= row_start;
                win_row_count <= row_count;
            end
        end
    end

`ifdef MIPI_IMG_GEOM_EN
    logic [DIM_WIDTH-1:0] last_width;
    logic                 line_done;

    assign line_done = (state == ST_LINE) && (lv_fall || fv_fall);

    // A frame that ends mid-line reports the partial line as its last line.
    always_ff @(posedge img_clk) begin
        if (reset) begin
            last_width  <= '0;
            meas_width  <= '0;
            meas_height <= '0;
            geom_valid  <= 1'b0;
        end else begin
            if (load_win) begin
                last_width <= '0;
            end else if (line_done) begin
                last_width <= col_cnt;
            end
            if (frame_done) begin
                meas_width  <= (state == ST_LINE) ? col_cnt : last_width;
                meas_height <= row_n;
                geom_valid  <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mipi_img_window.sv
// Directed self-checking bench for mipi_img_window; geometry checks run when MIPI_IMG_GEOM_EN is defined.
module tb_mipi_img_window;

    localparam int DW = 10;
    localparam int NW = 16;

    logic          img_clk = 1'b0;
    logic          reset   = 1'b1;
    logic          enable  = 1'b1;
    logic [DW-1:0] dati    = '0;
    logic          dvi     = 1'b0;
    logic          lvi     = 1'b0;
    logic          fvi     = 1'b0;
    logic [NW-1:0] col_start = '0, col_count = '0, row_start = '0, row_count = '0;
    logic [DW-1:0] dato;
    logic          dvo, lvo, fvo;
    logic [15:0]   frame_count;
`ifdef MIPI_IMG_GEOM_EN
    logic [NW-1:0] meas_width, meas_height;
    logic          geom_valid;
`endif

    int checks = 0;
    int errors = 0;

    int            dvo_cnt, lat_bad, lvo_pulses, fvo_pulses;
    logic [DW-1:0] data_q[$];
    logic          lvo_prev = 1'b0, fvo_prev = 1'b0, p_dvi = 1'b0, p_lvi = 1'b0;
    logic [DW-1:0] p_dati = '0;

    mipi_img_window dut (
        .img_clk     (img_clk),
        .reset       (reset),
        .enable      (enable),
        .dati        (dati),
        .dvi         (dvi),
        .lvi         (lvi),
        .fvi         (fvi),
        .col_start   (col_start),
        .col_count   (col_count),
        .row_start   (row_start),
        .row_count   (row_count),
        .dato        (dato),
        .dvo         (dvo),
        .lvo         (lvo),
        .fvo         (fvo),
        .frame_count (frame_count)
`ifdef MIPI_IMG_GEOM_EN
        ,
        .meas_width  (meas_width),
        .meas_height (meas_height),
        .geom_valid  (geom_valid)
`endif
    );

    always #5 img_clk = ~img_clk;

    // Output observer: collects emitted pixels, strobe pulses, and flags any dvo
    // not preceded one cycle earlier by an in-line dvi carrying the same data.
    always @(negedge img_clk) begin
        if (dvo) begin
            dvo_cnt++;
            data_q.push_back(dato);
            if (!(p_dvi && p_lvi) || (dato !== p_dati)) lat_bad++;
        end
        if (lvo && !lvo_prev) lvo_pulses++;
        if (fvo && !fvo_prev) fvo_pulses++;
        lvo_prev = lvo;
        fvo_prev = fvo;
        p_dvi    = dvi;
        p_lvi    = lvi;
        p_dati   = dati;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge img_clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        dvo_cnt    = 0;
        lat_bad    = 0;
        lvo_pulses = 0;
        fvo_pulses = 0;
        data_q.delete();
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Expected pixels form a ramp sub-rectangle: value = row*16 + col.
    task automatic check_ramp(input string tag, input int r0, input int nr, input int c0, input int nc);
        check_output({tag, "_count"}, data_q.size(), nr * nc);
        for (int r = 0; r < nr; r++) begin
            for (int c = 0; c < nc; c++) begin
                if (r * nc + c < data_q.size())
                    check_output({tag, "_pix"}, data_q[r * nc + c], (r0 + r) * 16 + (c0 + c));
            end
        end
    endtask

    task automatic set_window(input int cs, input int cc, input int rs, input int rc);
        col_start = NW'(cs);
        col_count = NW'(cc);
        row_start = NW'(rs);
        row_count = NW'(rc);
    endtask

    task automatic frame_begin();
        fvi = 1'b1;
        tick(2);
    endtask

    task automatic send_pixels(input int row, input int c_from, input int c_to, input bit bubbles);
        for (int c = c_from; c < c_to; c++) begin
            dvi  = 1'b1;
            dati = DW'(row * 16 + c);
            tick(1);
            if (bubbles && (c % 4 == 3) && (c != c_to - 1)) begin
                dvi  = 1'b0;
                dati = '1;
                tick(1);
            end
        end
    endtask

    task automatic send_line(input int row, input int ncols, input bit bubbles);
        lvi = 1'b1;
        dvi = 1'b0;
        tick(1);
        send_pixels(row, 0, ncols, bubbles);
        lvi  = 1'b0;
        dvi  = 1'b0;
        dati = '1;
        tick(2);
    endtask

    task automatic frame_end();
        fvi = 1'b0;
        tick(3);
    endtask

    task automatic send_frame(input int rows, input int cols, input bit bubbles);
        frame_begin();
        for (int r = 0; r < rows; r++) send_line(r, cols, bubbles);
        frame_end();
    endtask

    initial begin
        clear_mon();
        $display("[TB] reset state");
        tick(3);
        @(negedge img_clk);
        check_output("reset_dvo", dvo, 0);
        check_output("reset_lvo", lvo, 0);
        check_output("reset_fvo", fvo, 0);
        check_output("reset_dato", dato, 0);
        check_output("reset_frame_count", frame_count, 0);
        reset = 1'b0;
        tick(2);

        $display("[TB] full window passthrough");
        clear_mon();
        set_window(0, 8, 0, 4);
        send_frame(4, 8, 1'b0);
        check_output("pass_dvo_count", dvo_cnt, 32);
        check_output("pass_latency", lat_bad, 0);
        check_output("pass_lvo_pulses", lvo_pulses, 4);
        check_output("pass_fvo_pulses", fvo_pulses, 1);
        check_output("pass_frame_count", frame_count, 1);
        check_ramp("pass", 0, 4, 0, 8);

        $display("[TB] crop 2/3 x 1/2");
        clear_mon();
        set_window(2, 3, 1, 2);
        send_frame(4, 8, 1'b0);
        check_ramp("crop", 1, 2, 2, 3);
        check_output("crop_lvo_pulses", lvo_pulses, 2);
        check_output("crop_latency", lat_bad, 0);
        check_output("crop_frame_count", frame_count, 2);

        $display("[TB] packing bubbles");
        clear_mon();
        set_window(4, 4, 0, 2);
        send_frame(2, 10, 1'b1);
        check_ramp("bubble", 0, 2, 4, 4);
        check_output("bubble_latency", lat_bad, 0);
        check_output("bubble_lvo_pulses", lvo_pulses, 2);
        check_output("bubble_frame_count", frame_count, 3);

        $display("[TB] enable low at frame start");
        clear_mon();
        set_window(0, 8, 0, 4);
        enable = 1'b0;
        frame_begin();
        enable = 1'b1;
        send_line(0, 4, 1'b0);
        send_line(1, 4, 1'b0);
        frame_end();
        check_output("skip_fvo_pulses", fvo_pulses, 0);
        check_output("skip_dvo_count", dvo_cnt, 0);
        check_output("skip_frame_count", frame_count, 3);
        clear_mon();
        set_window(0, 4, 0, 2);
        send_frame(2, 4, 1'b0);
        check_output("after_skip_dvo_count", dvo_cnt, 8);
        check_output("after_skip_frame_count", frame_count, 4);

        $display("[TB] truncated window and mid-frame config change");
        clear_mon();
        set_window(6, 10, 0, 1);
        frame_begin();
        set_window(0, 8, 0, 4);
        send_line(0, 8, 1'b0);
        send_line(1, 8, 1'b0);
        frame_end();
        check_ramp("trunc", 0, 1, 6, 2);
        check_output("trunc_frame_count", frame_count, 5);

        $display("[TB] empty window");
        clear_mon();
        set_window(0, 0, 0, 4);
        send_frame(2, 4, 1'b0);
        check_output("empty_dvo_count", dvo_cnt, 0);
        check_output("empty_lvo_pulses", lvo_pulses, 0);
        check_output("empty_fvo_pulses", fvo_pulses, 1);
        check_output("empty_frame_count", frame_count, 6);

        $display("[TB] reset mid-line");
        set_window(0, 8, 0, 4);
        frame_begin();
        lvi = 1'b1;
        dvi = 1'b0;
        tick(1);
        send_pixels(0, 0, 3, 1'b0);
        dvi   = 1'b1;
        dati  = DW'(3);
        reset = 1'b1;
        tick(1);
        @(negedge img_clk);
        check_output("midreset_dvo", dvo, 0);
        check_output("midreset_lvo", lvo, 0);
        check_output("midreset_fvo", fvo, 0);
        check_output("midreset_frame_count", frame_count, 0);
        #1;
        reset = 1'b0;
        clear_mon();
        send_pixels(0, 4, 8, 1'b0);
        lvi = 1'b0;
        dvi = 1'b0;
        tick(2);
        for (int r = 1; r < 4; r++) send_line(r, 8, 1'b0);
        frame_end();
        check_output("midreset_rest_dvo", dvo_cnt, 0);
        check_output("midreset_rest_fvo", fvo_pulses, 0);
        check_output("midreset_rest_frame_count", frame_count, 0);
        clear_mon();
        set_window(0, 4, 0, 2);
        send_frame(2, 4, 1'b0);
        check_output("post_reset_dvo_count", dvo_cnt, 8);
        check_output("post_reset_frame_count", frame_count, 1);

`ifdef MIPI_IMG_GEOM_EN
        $display("[TB] geometry measurement");
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        @(negedge img_clk);
        check_output("geom_reset_valid", geom_valid, 0);
        check_output("geom_reset_width", meas_width, 0);
        check_output("geom_reset_height", meas_height, 0);
        #1;
        clear_mon();
        set_window(0, 0, 0, 0);
        send_frame(6, 12, 1'b0);
        check_output("geom_dvo_count", dvo_cnt, 0);
        check_output("geom_width", meas_width, 12);
        check_output("geom_height", meas_height, 6);
        check_output("geom_valid", geom_valid, 1);
        check_output("geom_frame_count", frame_count, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
